// File: rtl/dac_fmt_pkg.sv
// Shared definitions for the multi-channel DAC sample formatter: source
// select encodings and offset-binary helpers.
package dac_fmt_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned HELPER_W = 32;

  typedef enum logic [MODE_W-1:0] {
    MODE_FIR  = 2'd0,
    MODE_BIT  = 2'd1,
    MODE_MID  = 2'd2,
    MODE_RAMP = 2'd3
  } mode_e;

  // Midscale code 2^(w-1); callers keep the low w bits.
  function automatic logic [HELPER_W-1:0] midscale(input int unsigned w);
    return HELPER_W'(1) << (w - 1);
  endfunction

  // Two's complement value in the low w bits -> offset binary (MSB inverted).
  function automatic logic [HELPER_W-1:0] to_offset_bin(input logic [HELPER_W-1:0] v,
                                                        input int unsigned w);
    logic [HELPER_W-1:0] mask;
    mask = (w >= HELPER_W) ? '1 : ((HELPER_W'(1) << w) - HELPER_W'(1));
    return (v ^ midscale(w)) & mask;
  endfunction

endpackage

// File: rtl/dac_fmt_lane.sv
// One DAC channel: stage 1 captures source selects and the rounded/shifted
// FIR sample; stage 2 clamps, converts to offset binary and holds the code.
module dac_fmt_lane
  import dac_fmt_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned DAC_W = 14,
  parameter int unsigned SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              fmt,
  input  logic              hold_mid,
  input  logic [MODE_W-1:0] mode,
  input  logic              bit_in,
  input  logic [IN_W-1:0]   din,
  input  logic [DAC_W-1:0]  ramp,
  output logic [DAC_W-1:0]  code,
  output logic              sat_c
);

  localparam int unsigned SUM_W  = IN_W + 1;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [SUM_W-1:0] RND  = (SHIFT > 0) ? (SUM_W'(1) << RND_SH) : SUM_W'(0);
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((2 ** (DAC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MINV = ~MAXV;
  localparam logic [DAC_W-1:0] MID = DAC_W'(midscale(DAC_W));

  mode_e                   mode_q;
  logic                    bit_q;
  logic [DAC_W-1:0]        ramp_q;
  logic signed [SUM_W-1:0] r_q;

  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] r_c;
  logic signed [SUM_W-1:0] clamp_c;
  logic                    hi_c;
  logic                    lo_c;
  logic [DAC_W-1:0]        fmt_c;

  // Round half up in one extra bit so 0x7FFF plus the rounding term cannot wrap.
  always_comb begin
    sum_c = $signed({din[IN_W-1], din}) + RND;
    r_c   = sum_c >>> SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_FIR;
      bit_q  <= 1'b0;
      ramp_q <= '0;
      r_q    <= '0;
    end else if (load) begin
      mode_q <= mode_e'(mode);
      bit_q  <= bit_in;
      ramp_q <= ramp;
      r_q    <= r_c;
    end
  end

  always_comb begin
    hi_c    = (r_q > MAXV);
    lo_c    = (r_q < MINV);
    clamp_c = r_q;
    if (hi_c) clamp_c = MAXV;
    if (lo_c) clamp_c = MINV;
    fmt_c = MID;
    case (mode_q)
      MODE_FIR:  fmt_c = DAC_W'(to_offset_bin(HELPER_W'(clamp_c), DAC_W));
      MODE_BIT:  fmt_c = bit_q ? '1 : '0;
      MODE_MID:  fmt_c = MID;
      MODE_RAMP: fmt_c = ramp_q;
      default:   fmt_c = MID;
    endcase
    sat_c = (mode_q == MODE_FIR) && (hi_c || lo_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code <= MID;
    end else if (hold_mid) begin
      code <= MID;
    end else if (fmt) begin
      code <= fmt_c;
    end
  end

endmodule

// File: rtl/dac_fmt_mc.sv
// Multi-channel DAC sample formatter: shared ramp counter, enable gating,
// valid pipeline and sticky saturation flags around per-channel lanes.
module dac_fmt_mc
  import dac_fmt_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned DAC_W     = 14,
  parameter int unsigned SHIFT     = 2,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [MODE_W*NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0]       bit_in,
  input  logic [NUM_CH*IN_W-1:0]  din,
  input  logic                    din_vld,
  input  logic                    sat_clr,
  output logic [NUM_CH*DAC_W-1:0] dac_data,
  output logic                    dac_vld,
  output logic [NUM_CH-1:0]       sat_flag
);

  logic              accept_c;
  logic              fmt_c;
  logic              v1;
  logic [DAC_W-1:0]  ramp;
  logic [NUM_CH-1:0] sat_c;

  assign accept_c = din_vld & en;
  assign fmt_c    = v1 & en;

  // Dropping en flushes the pipeline and restarts the ramp from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      dac_vld  <= 1'b0;
      ramp     <= '0;
      sat_flag <= '0;
    end else begin
      v1       <= accept_c;
      dac_vld  <= fmt_c;
      sat_flag <= ({NUM_CH{fmt_c}} & sat_c) | (sat_flag & ~{NUM_CH{sat_clr}});
      if (!en) begin
        ramp <= '0;
      end else if (accept_c) begin
        ramp <= ramp + DAC_W'(RAMP_STEP);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    dac_fmt_lane #(
      .IN_W  (IN_W),
      .DAC_W (DAC_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (accept_c),
      .fmt      (fmt_c),
      .hold_mid (~en),
      .mode     (mode[k*MODE_W +: MODE_W]),
      .bit_in   (bit_in[k]),
      .din      (din[k*IN_W +: IN_W]),
      .ramp     (ramp),
      .code     (dac_data[k*DAC_W +: DAC_W]),
      .sat_c    (sat_c[k])
    );
  end

endmodule

// File: tb/tb_dac_fmt_mc.sv
// Self-checking bench for dac_fmt_mc: queue-based behavioural model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_dac_fmt_mc;

  localparam int NUM_CH = 2;
  localparam int IN_W   = 16;
  localparam int DAC_W  = 14;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b1;
  logic [2*NUM_CH-1:0]     mode = '0;
  logic [NUM_CH-1:0]       bit_in = '0;
  logic [NUM_CH*IN_W-1:0]  din = '0;
  logic                    din_vld = 1'b0;
  logic                    sat_clr = 1'b0;
  logic [NUM_CH*DAC_W-1:0] dac_data;
  logic                    dac_vld;
  logic [NUM_CH-1:0]       sat_flag;

  int pass_n = 0;
  int tot_n  = 0;

  dac_fmt_mc dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .bit_in   (bit_in),
    .din      (din),
    .din_vld  (din_vld),
    .sat_clr  (sat_clr),
    .dac_data (dac_data),
    .dac_vld  (dac_vld),
    .sat_flag (sat_flag)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // Expected code for one channel from the formatting rules, using plain integers.
  function automatic logic [13:0] model_code(input int m, input bit b, input logic [15:0] x,
                                              input int rmp, output bit sat);
    int v;
    int r;
    sat = 1'b0;
    case (m)
      0: begin
        v = int'($signed(x)) + 2;
        r = (v >= 0) ? v / 4 : -((-v + 3) / 4);
        if (r > 8191) begin r = 8191; sat = 1'b1; end
        else if (r < -8192) begin r = -8192; sat = 1'b1; end
        return 14'(r + 8192);
      end
      1: return b ? 14'h3FFF : 14'h0000;
      2: return 14'h2000;
      default: return 14'(rmp);
    endcase
  endfunction

  typedef struct packed {
    int          due;
    logic [27:0] codes;
    logic [1:0]  sat;
  } ent_t;

  localparam logic [27:0] MID2 = {14'h2000, 14'h2000};

  ent_t        q[$];
  int          edge_n = 0;
  int          m_ramp = 0;
  logic [27:0] m_data = MID2;
  bit          m_vld = 1'b0;
  logic [1:0]  m_flag = 2'b00;

  // Model advances on each rising edge from the inputs held there, then compares.
  always @(posedge clk) begin
    ent_t       e;
    logic [1:0] setv;
    bit         s;
    edge_n++;
    setv = 2'b00;
    if (rst) begin
      q.delete();
      m_ramp = 0;
      m_data = MID2;
      m_vld  = 1'b0;
      m_flag = 2'b00;
    end else if (!en) begin
      q.delete();
      m_ramp = 0;
      m_data = MID2;
      m_vld  = 1'b0;
      m_flag = m_flag & ~{2{sat_clr}};
    end else begin
      m_vld = 1'b0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        e      = q.pop_front();
        m_data = e.codes;
        m_vld  = 1'b1;
        setv   = e.sat;
      end
      m_flag = setv | (m_flag & ~{2{sat_clr}});
      if (din_vld) begin
        e = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
          e.codes[ch*14 +: 14] = model_code(int'(mode[2*ch +: 2]), bit_in[ch],
                                            din[ch*16 +: 16], m_ramp, s);
          e.sat[ch] = s;
        end
        e.due = edge_n + 1;
        q.push_back(e);
        m_ramp = (m_ramp + 1) % 16384;
      end
    end
    #1;
    chk("model dac_data", 32'(dac_data), 32'(m_data));
    chk("model dac_vld", 32'(dac_vld), 32'(m_vld));
    chk("model sat_flag", 32'(sat_flag), 32'(m_flag));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] d0, input logic [15:0] d1);
    din = {d1, d0};
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    step();
  endtask

  logic [15:0] fin[4];
  logic [13:0] fexp[4];

  initial begin
    fin  = '{16'h0000, 16'h0006, 16'hFFFA, 16'h8000};
    fexp = '{14'h2000, 14'h2002, 14'h1FFF, 14'h0000};

    repeat (3) step();
    chk("reset ch0", 32'(dac_data[13:0]), 32'h2000);
    chk("reset ch1", 32'(dac_data[27:14]), 32'h2000);
    chk("reset vld", 32'(dac_vld), 32'h0);
    chk("reset sat", 32'(sat_flag), 32'h0);
    rst = 1'b0;
    step();

    // FIR rounding and the negative full-scale boundary
    mode = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      pulse(fin[i], 16'h0000);
      chk("fir ch0", 32'(dac_data[13:0]), 32'(fexp[i]));
      chk("fir vld", 32'(dac_vld), 32'h1);
      chk("fir sat0", 32'(sat_flag[0]), 32'h0);
    end

    // Positive saturation, sticky flag, set-beats-clear, then clear
    pulse(16'h0000, 16'h7FFF);
    chk("sat ch1", 32'(dac_data[27:14]), 32'h3FFF);
    chk("sat flag1", 32'(sat_flag[1]), 32'h1);
    repeat (3) step();
    chk("sat held", 32'(sat_flag[1]), 32'h1);
    din = {16'h7FFF, 16'h0000};
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("sat set wins", 32'(sat_flag[1]), 32'h1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("sat cleared", 32'(sat_flag), 32'h0);

    // BIT on ch0, MID on ch1 regardless of din
    mode = 4'b1001;
    bit_in = 2'b01;
    pulse(16'h0000, 16'h7FFF);
    chk("bit1 ch0", 32'(dac_data[13:0]), 32'h3FFF);
    chk("mid ch1", 32'(dac_data[27:14]), 32'h2000);
    bit_in = 2'b00;
    pulse(16'h0000, 16'h7FFF);
    chk("bit0 ch0", 32'(dac_data[13:0]), 32'h0000);
    chk("no sat mid", 32'(sat_flag), 32'h0);

    // Ramp through a full wrap with din_vld held
    en = 1'b0;
    step();
    en = 1'b1;
    mode = 4'b1111;
    din_vld = 1'b1;
    step();
    step();
    chk("ramp first", 32'(dac_data), 32'h0);
    chk("ramp first vld", 32'(dac_vld), 32'h1);
    repeat (16384) step();
    din_vld = 1'b0;
    step();
    chk("ramp wrap ch0", 32'(dac_data[13:0]), 32'h0001);
    chk("ramp wrap ch1", 32'(dac_data[27:14]), 32'h0001);

    // Enable drop when the ramp sits at 0x0123
    en = 1'b0;
    step();
    en = 1'b1;
    din_vld = 1'b1;
    repeat (12'h123) step();
    en = 1'b0;
    step();
    chk("en drop data", 32'(dac_data), 32'(MID2));
    chk("en drop vld", 32'(dac_vld), 32'h0);
    en = 1'b1;
    step();
    chk("en rise gap", 32'(dac_vld), 32'h0);
    step();
    chk("en rise data", 32'(dac_data), 32'h0);
    chk("en rise vld", 32'(dac_vld), 32'h1);

    // Reset mid-stream discards in-flight samples
    rst = 1'b1;
    step();
    chk("rst mid data", 32'(dac_data), 32'(MID2));
    chk("rst mid vld", 32'(dac_vld), 32'h0);
    rst = 1'b0;
    din_vld = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
